tank_blitter: RTL and testbench
===============================

Name: tank_blitter

Overview:
- Writer end of the tank glyph lookup path.
- On a start pulse it walks glyph coordinates (0..15, 0..15) and reads the 1-bit glyph pixel returned by the glyph lookup.
- For every set pixel that lands on screen, it issues a framebuffer write with a ready/valid-style handshake.
- Sits between game logic (tank position/orientation) and the framebuffer write port.

Parameters:
- SCREEN_W, 640, visible width in pixels; framebuffer row pitch.
- SCREEN_H, 480, visible height in pixels.
- FB_ADDR_BITS, 19, framebuffer address width (must hold SCREEN_W*SCREEN_H-1).
- COLOR_BITS, 8, framebuffer pixel data width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle request to blit; honoured only in IDLE
- tank_x  in  10  screen x of glyph column 0; latched on accepted start
- tank_y  in  9  screen y of glyph row 0; latched on accepted start
- tank_direction  in  1  passed to glyph lookup; latched on start
- tank_y_flip  in  1  passed to glyph lookup; latched on start
- color  in  COLOR_BITS  write colour; latched on start
- glyph_x  out  4  glyph column to lookup
- glyph_y  out  4  glyph row to lookup
- glyph_direction  out  1  latched tank_direction
- glyph_y_flip  out  1  latched tank_y_flip
- glyph_pixel  in  1  combinational pixel from lookup for current glyph_x/glyph_y
- fb_we  out  1  write valid
- fb_addr  out  FB_ADDR_BITS  write address = py*SCREEN_W + px
- fb_data  out  COLOR_BITS  write data
- fb_ready  in  1  framebuffer accepts write at the clock edge where fb_we&&fb_ready
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse when the blit completes

Behaviour:
- Reset values: state IDLE; glyph_x=glyph_y=0; glyph_direction=glyph_y_flip=0; fb_we=0; fb_addr=0; fb_data=0; busy=0; done=0; latched position/colour=0. Reset at any point, including mid-write, aborts to IDLE in one cycle. No pending write survives reset.
- IDLE:
  - On start=1: latch inputs, clear glyph_x/glyph_y to 0, set busy=1, go to FETCH.
  - start is ignored in all other states.
- FETCH (one cycle per glyph pixel):
  - px = tank_x + glyph_x (11-bit); py = tank_y + glyph_y (10-bit). No wrap.
  - A pixel is visible iff px < SCREEN_W and py < SCREEN_H.
  - If glyph_pixel=1 and visible: register fb_addr and fb_data=color, set fb_we=1, go to WRITE.
  - Otherwise advance the coordinate and stay in FETCH, or go to FIN after (15,15).
- WRITE:
  - Hold fb_we, fb_addr and fb_data stable until a rising edge with fb_ready=1.
  - At that edge: fb_we=0, advance the coordinate, return to FETCH, or go to FIN after (15,15).
  - fb_ready while fb_we=0 has no effect.
- Coordinate advance: glyph_x increments 0..15; on 15 it wraps to 0 and glyph_y increments. Row-major order.
- FIN: done=1 for exactly one cycle, busy=0 in the same cycle, next state IDLE.
- Throughput: with fb_ready tied high, a blit takes 256 + N cycles from busy rising to done, where N is the number of visible set pixels. Each ready-low cycle adds one cycle.
- glyph_direction and glyph_y_flip hold the latched values for the whole blit. They do not change when inputs change mid-blit.
- fb_addr arithmetic is done at full product width, then truncated to FB_ADDR_BITS. Values are always in range because writes are clipped.

Optional Feature:
- Macro: TANK_BLITTER_ERASE_EN.
- When defined:
  - Adds input port erase (1 bit), latched on start.
  - If latched erase=1, fb_data is driven as all-zeros instead of color, for the same set-pixel/visible pattern. This erases a previously drawn tank.
  - Cycle timing is identical.
- When undefined: no erase port; fb_data always equals the latched color.

Test Plan:
- Reset, then start with tank_x=100, tank_y=50, color=8'hA5, glyph all-ones, fb_ready=1 -> 256 writes at addr 50*640+100 .. 65*640+115 in row-major order, data A5; done pulses at cycle 512 after busy rises.
- Glyph all-zeros, start -> fb_we never asserts; done pulses exactly 256 cycles after busy rises.
- tank_x=630, tank_y=470, glyph all-ones -> only 100 writes (px 630..639, py 470..479); no address >= 307200.
- fb_ready held low 5 cycles on the first write -> fb_we, fb_addr and fb_data stay stable for 6 cycles; total blit length grows by 5.
- start pulsed again mid-blit and tank_x changed -> ignored, addresses unchanged; reset asserted during WRITE -> next cycle fb_we=0, busy=0, IDLE.
- With TANK_BLITTER_ERASE_EN, erase=1, glyph checkerboard -> 128 writes with fb_data=0; with erase=0 -> fb_data=color.

Source files
------------

// File: rtl/tank_blitter_if.sv
// Framebuffer write port of the tank blitter: write valid/address/data with a ready back-pressure.
interface tank_blitter_if #(
    parameter int FB_ADDR_BITS = 19,
    parameter int COLOR_BITS   = 8
);
    logic                    fb_we;
    logic [FB_ADDR_BITS-1:0] fb_addr;
    logic [COLOR_BITS-1:0]   fb_data;
    logic                    fb_ready;

    modport master (output fb_we, output fb_addr, output fb_data, input fb_ready);
    modport slave  (input fb_we, input fb_addr, input fb_data, output fb_ready);
endinterface

// File: rtl/tank_blitter.sv
// Walks a 16x16 tank glyph and writes every visible set pixel to the framebuffer.
// Optional macro TANK_BLITTER_ERASE_EN adds an erase input that forces written data to zero.
module tank_blitter #(
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480,
    parameter int FB_ADDR_BITS = 19,
    parameter int COLOR_BITS   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [9:0]            tank_x,
    input  logic [8:0]            tank_y,
    input  logic                  tank_direction,
    input  logic                  tank_y_flip,
    input  logic [COLOR_BITS-1:0] color,
`ifdef TANK_BLITTER_ERASE_EN
    input  logic                  erase,
`endif
    output logic [3:0]            glyph_x,
    output logic [3:0]            glyph_y,
    output logic                  glyph_direction,
    output logic                  glyph_y_flip,
    input  logic                  glyph_pixel,
    tank_blitter_if.master        fb,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WRITE, S_FIN} state_t;

    localparam logic [31:0] LP_W = SCREEN_W;
    localparam logic [31:0] LP_H = SCREEN_H;

    state_t                  r_state;
    state_t                  w_next;
    logic [9:0]              r_tank_x;
    logic [8:0]              r_tank_y;
    logic                    r_dir;
    logic                    r_flip;
    logic [COLOR_BITS-1:0]   r_color;
    logic                    r_erase;
    logic [3:0]              r_gx;
    logic [3:0]              r_gy;
    logic [FB_ADDR_BITS-1:0] r_addr;
    logic [COLOR_BITS-1:0]   r_data;

    logic [10:0] w_px;
    logic [9:0]  w_py;
    logic        w_hit;
    logic        w_last;
    logic        w_advance;
    logic        w_erase_in;

`ifdef TANK_BLITTER_ERASE_EN
    assign w_erase_in = erase;
`else
    assign w_erase_in = 1'b0;
`endif

    // Screen position of the current glyph pixel; no wrap, clipped below.
    assign w_px      = {1'b0, r_tank_x} + {7'b0, r_gx};
    assign w_py      = {1'b0, r_tank_y} + {6'b0, r_gy};
    assign w_hit     = glyph_pixel && (32'(w_px) < LP_W) && (32'(w_py) < LP_H);
    assign w_last    = (r_gx == 4'hF) && (r_gy == 4'hF);
    assign w_advance = ((r_state == S_FETCH) && !w_hit) ||
                       ((r_state == S_WRITE) && fb.fb_ready);

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_FETCH;
            S_FETCH: if (w_hit) w_next = S_WRITE;
                     else if (w_last) w_next = S_FIN;
            S_WRITE: if (fb.fb_ready) w_next = w_last ? S_FIN : S_FETCH;
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tank_x <= '0;
            r_tank_y <= '0;
            r_dir    <= 1'b0;
            r_flip   <= 1'b0;
            r_color  <= '0;
            r_erase  <= 1'b0;
            r_gx     <= '0;
            r_gy     <= '0;
            r_addr   <= '0;
            r_data   <= '0;
        end else begin
            if ((r_state == S_IDLE) && start) begin
                r_tank_x <= tank_x;
                r_tank_y <= tank_y;
                r_dir    <= tank_direction;
                r_flip   <= tank_y_flip;
                r_color  <= color;
                r_erase  <= w_erase_in;
                r_gx     <= '0;
                r_gy     <= '0;
            end
            // Row-major walk; the 8-bit carry naturally wraps back to (0,0) after (15,15).
            if (w_advance) {r_gy, r_gx} <= {r_gy, r_gx} + 8'd1;
            if ((r_state == S_FETCH) && w_hit) begin
                r_addr <= FB_ADDR_BITS'(32'(w_py) * LP_W + 32'(w_px));
                r_data <= r_erase ? '0 : r_color;
            end
        end
    end

    always_comb begin
        busy  = (r_state == S_FETCH) || (r_state == S_WRITE);
        done  = (r_state == S_FIN);
        fb.fb_we = (r_state == S_WRITE);
    end

    assign fb.fb_addr      = r_addr;
    assign fb.fb_data      = r_data;
    assign glyph_x         = r_gx;
    assign glyph_y         = r_gy;
    assign glyph_direction = r_dir;
    assign glyph_y_flip    = r_flip;

endmodule

// File: tb/tb_tank_blitter.sv
// Directed bench for tank_blitter: glyph patterns, clipping, back-pressure, restart and reset aborts.
module tb_tank_blitter;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [9:0] tank_x;
    logic [8:0] tank_y;
    logic       tank_direction;
    logic       tank_y_flip;
    logic [7:0] color;
    logic       erase;
    logic [3:0] glyph_x;
    logic [3:0] glyph_y;
    logic       glyph_direction;
    logic       glyph_y_flip;
    logic       glyph_pixel;
    logic       busy;
    logic       done;
    int         g_mode;

    int vectors = 0;
    int miscompares = 0;

    tank_blitter_if #(.FB_ADDR_BITS(19), .COLOR_BITS(8)) fbif ();

    tank_blitter dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .tank_x          (tank_x),
        .tank_y          (tank_y),
        .tank_direction  (tank_direction),
        .tank_y_flip     (tank_y_flip),
        .color           (color),
`ifdef TANK_BLITTER_ERASE_EN
        .erase           (erase),
`endif
        .glyph_x         (glyph_x),
        .glyph_y         (glyph_y),
        .glyph_direction (glyph_direction),
        .glyph_y_flip    (glyph_y_flip),
        .glyph_pixel     (glyph_pixel),
        .fb              (fbif.master),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    // Glyph patterns: 0 = blank, 1 = solid, 2 = checkerboard.
    function automatic logic pix(input int mode, input int x, input int y);
        if (mode == 1) return 1'b1;
        if (mode == 2) return 1'(((x ^ y) & 1) != 0);
        return 1'b0;
    endfunction

    assign glyph_pixel = pix(g_mode, int'(glyph_x), int'(glyph_y));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_blit(input string name, input int tx, input int ty, input int mode,
                            input logic [7:0] col, input logic er, input int stall_n,
                            input int restart_at, input int exp_writes, input int exp_cycles);
        int         q[$];
        int         c;
        int         nwr;
        int         stall;
        logic [7:0] exp_data;
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++)
                if (pix(mode, x, y) && (tx + x) < 640 && (ty + y) < 480)
                    q.push_back((ty + y) * 640 + tx + x);
        exp_data       = er ? 8'h00 : col;
        g_mode         = mode;
        tank_x         = 10'(tx);
        tank_y         = 9'(ty);
        tank_direction = 1'b1;
        tank_y_flip    = 1'b1;
        color          = col;
        erase          = er;
        fbif.fb_ready  = 1'b1;
        start          = 1'b1;
        tick();
        start = 1'b0;
        check({name, "_busy_rise"}, 32'(busy), 32'd1);
        check({name, "_glyph_xy0"}, {24'd0, glyph_y, glyph_x}, 32'd0);
        c     = 0;
        nwr   = 0;
        stall = stall_n;
        while (!done && c < exp_cycles + 64) begin
            if (c == restart_at) begin
                start          = 1'b1;
                tank_x         = 10'd300;
                tank_direction = 1'b0;
                tank_y_flip    = 1'b0;
            end else begin
                start = 1'b0;
            end
            if (fbif.fb_we) begin
                if (q.size() == 0) begin
                    check({name, "_extra_write"}, 32'(fbif.fb_addr), 32'hFFFFFFFF);
                end else begin
                    check({name, "_addr"}, 32'(fbif.fb_addr), 32'(q[0]));
                    check({name, "_data"}, 32'(fbif.fb_data), 32'(exp_data));
                end
                if (stall > 0) begin
                    fbif.fb_ready = 1'b0;
                    stall--;
                end else begin
                    fbif.fb_ready = 1'b1;
                    if (q.size() > 0) void'(q.pop_front());
                    nwr++;
                end
            end else begin
                fbif.fb_ready = 1'b1;
            end
            tick();
            c++;
            if (restart_at >= 0 && c == restart_at + 1) begin
                check({name, "_dir_held"}, 32'(glyph_direction), 32'd1);
                check({name, "_flip_held"}, 32'(glyph_y_flip), 32'd1);
            end
        end
        start = 1'b0;
        check({name, "_done"}, 32'(done), 32'd1);
        check({name, "_busy_at_done"}, 32'(busy), 32'd0);
        check({name, "_cycles"}, 32'(c), 32'(exp_cycles));
        check({name, "_writes"}, 32'(nwr), 32'(exp_writes));
        tick();
        check({name, "_done_pulse"}, 32'(done), 32'd0);
        check({name, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        reset          = 1'b1;
        start          = 1'b0;
        tank_x         = '0;
        tank_y         = '0;
        tank_direction = 1'b0;
        tank_y_flip    = 1'b0;
        color          = '0;
        erase          = 1'b0;
        g_mode         = 0;
        fbif.fb_ready  = 1'b1;
        tick();
        tick();
        check("rst_fb_we", 32'(fbif.fb_we), 32'd0);
        check("rst_fb_addr", 32'(fbif.fb_addr), 32'd0);
        check("rst_fb_data", 32'(fbif.fb_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_glyph", {24'd0, glyph_y, glyph_x}, 32'd0);
        check("rst_dir_flip", {30'd0, glyph_direction, glyph_y_flip}, 32'd0);
        reset = 1'b0;
        tick();

        run_blit("solid",   100, 50,  1, 8'hA5, 1'b0, 0, -1, 256, 512);
        run_blit("blank",   100, 50,  0, 8'hA5, 1'b0, 0, -1, 0,   256);
        run_blit("corner",  630, 470, 1, 8'h11, 1'b0, 0, -1, 100, 356);
        run_blit("stall",   200, 100, 1, 8'h5A, 1'b0, 5, -1, 256, 517);
        run_blit("restart", 100, 50,  1, 8'hC3, 1'b0, 0, 20, 256, 512);
        run_blit("checker", 10,  20,  2, 8'h3C, 1'b0, 0, -1, 128, 384);
`ifdef TANK_BLITTER_ERASE_EN
        run_blit("erase",   10,  20,  2, 8'h3C, 1'b1, 0, -1, 128, 384);
`endif

        // Abort in the middle of a held write.
        g_mode        = 1;
        tank_x        = 10'd100;
        tank_y        = 9'd50;
        color         = 8'h77;
        erase         = 1'b0;
        fbif.fb_ready = 1'b0;
        start         = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10 && !fbif.fb_we; i++) tick();
        check("abort_in_write", 32'(fbif.fb_we), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_fb_we", 32'(fbif.fb_we), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_addr", 32'(fbif.fb_addr), 32'd0);
        tick();
        check("abort_stays_idle", {30'd0, busy, fbif.fb_we}, 32'd0);
        fbif.fb_ready = 1'b1;

        run_blit("post_abort", 0, 0, 1, 8'h01, 1'b0, 0, -1, 256, 512);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
